trig_stage_ng: RTL

Parametrised next-generation trigger stage for the logIP capture core. It compares strobed sample words against a programmed mask/value pair, in parallel or serial mode. It qualifies a trigger by armed level and a consecutive-match repeat count, then delays it by a programmable number of strobes. When it fires it emits a match pulse and, optionally, a run pulse to the sampler. Several instances sit side by side in the trigger unit, fed by the command decoder and chained through the shared level counter.

---
 rtl/trig_stage_ng.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/trig_stage_ng.sv
//==============================================================================
// Module   : trig_stage_ng
// Purpose  : Mask/value trigger stage with level gating, repeat qualification
//            and strobe-counted delay; emits one-cycle match/run pulses.
// Revision : 1.0
//==============================================================================
`default_nettype none

module trig_stage_ng #(
    parameter int WIDTH   = 32,
    parameter int DELAY_W = 16,
    parameter int LVL_W   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        cmd_i,
    input  logic               set_mask_i,
    input  logic               set_val_i,
    input  logic               set_cfg_i,
    input  logic               arm_i,
    input  logic               stb_i,
    input  logic [WIDTH-1:0]   smpls_i,
    input  logic [LVL_W-1:0]   lvl_i,
    output logic               match_o,
    output logic               run_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DELAY = 2'd2,
        S_FIRED = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_mask;
    logic [WIDTH-1:0]   r_val;
    logic [DELAY_W-1:0] r_delay;
    logic [LVL_W-1:0]   r_level;
    logic [4:0]         r_chan;
    logic               r_serial;
    logic               r_start;
    logic [3:0]         r_repeat;

    logic [WIDTH-1:0]   r_sreg;
    logic [WIDTH-1:0]   w_sreg_nxt;
    logic [WIDTH-1:0]   w_sreg_shift;
    logic [3:0]         r_rep;
    logic [3:0]         w_rep_nxt;
    logic [DELAY_W-1:0] r_dcnt;
    logic [DELAY_W-1:0] w_dcnt_nxt;

    logic               r_match;
    logic               r_run;

    logic               w_chan_bit;
    logic [WIDTH-1:0]   w_word;
    logic               w_hit;
    logic               w_active;
    logic               w_fire;
    logic               w_unused;

    // Some command bits are unused for narrower parameter choices.
    assign w_unused = ^cmd_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mask   <= '0;
            r_val    <= '0;
            r_delay  <= '0;
            r_level  <= '0;
            r_chan   <= '0;
            r_serial <= 1'b0;
            r_start  <= 1'b0;
            r_repeat <= '0;
        end else begin
            if (set_mask_i) begin
                r_mask <= cmd_i[WIDTH-1:0];
            end
            if (set_val_i) begin
                r_val <= cmd_i[WIDTH-1:0];
            end
            if (set_cfg_i) begin
                r_delay  <= cmd_i[DELAY_W-1:0];
                r_level  <= cmd_i[16 +: LVL_W];
                r_chan   <= cmd_i[24:20];
                r_serial <= cmd_i[26];
                r_start  <= cmd_i[27];
                r_repeat <= cmd_i[31:28];
            end
        end
    end

    // Channels beyond the sample width read as constant zero.
    always_comb begin
        w_chan_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_chan == 5'(i)) begin
                w_chan_bit = smpls_i[i];
            end
        end
    end

    generate
        if (WIDTH == 1) begin : g_sreg_w1
            assign w_sreg_shift = w_chan_bit;
        end else begin : g_sreg_wn
            assign w_sreg_shift = {r_sreg[WIDTH-2:0], w_chan_bit};
        end
    endgenerate

    assign w_word   = r_serial ? w_sreg_shift : smpls_i;
    assign w_hit    = ((w_word ^ r_val) & r_mask) == '0;
    assign w_active = (lvl_i >= r_level);

    always_comb begin
        w_state_nxt = r_state;
        w_rep_nxt   = r_rep;
        w_dcnt_nxt  = r_dcnt;
        w_sreg_nxt  = r_sreg;
        w_fire      = 1'b0;

        if (arm_i) begin
            w_state_nxt = S_ARMED;
            w_rep_nxt   = '0;
            w_dcnt_nxt  = '0;
            w_sreg_nxt  = '0;
        end else if (stb_i) begin
            case (r_state)
                S_ARMED: begin
                    if (w_active) begin
                        if (r_serial) begin
                            w_sreg_nxt = w_sreg_shift;
                        end
                        if (w_hit) begin
                            if (r_rep >= r_repeat) begin
                                if (r_delay == '0) begin
                                    w_fire = 1'b1;
                                end else begin
                                    w_dcnt_nxt  = DELAY_W'(1);
                                    w_state_nxt = S_DELAY;
                                end
                            end
                            if (r_rep != 4'hF) begin
                                w_rep_nxt = r_rep + 4'd1;
                            end
                        end else begin
                            w_rep_nxt = '0;
                        end
                    end
                end
                S_DELAY: begin
                    // >= keeps the counter bounded if delay is lowered mid-count.
                    if (r_dcnt >= r_delay) begin
                        w_fire = 1'b1;
                    end else begin
                        w_dcnt_nxt = r_dcnt + DELAY_W'(1);
                    end
                end
                default: ;
            endcase
        end

        if (w_fire) begin
            w_state_nxt = S_FIRED;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_rep   <= '0;
            r_dcnt  <= '0;
            r_sreg  <= '0;
            r_match <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rep   <= w_rep_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_sreg  <= w_sreg_nxt;
            r_match <= w_fire;
            r_run   <= w_fire & r_start;
        end
    end

    assign match_o = r_match;
    assign run_o   = r_run;

endmodule

`default_nettype wire
